// File: rtl/frame_capture_sink.sv
// frame_capture_sink: frame/line-valid pixel sink with geometry checks, address tagging and a valid/ready FIFO
// Ports: clk, rst_n (async, active-low); b_fval/b_lval/in_data pixel stream in;
//        out_valid/out_ready/out_data/out_addr/out_last drain handshake;
//        frame_done, frame_cnt, err_line_len, err_line_cnt, overflow, frame_crc status.
// Option: define CAPTURE_CRC_EN to compute a CRC-16-CCITT over each frame's pushed pixels.
`timescale 1ns/1ps
module frame_capture_sink #(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(WIDTH*HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  b_fval,
  input  logic                  b_lval,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_last,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  err_line_len,
  output logic                  err_line_cnt,
  output logic                  overflow,
  output logic [15:0]           frame_crc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DATA_WIDTH + 1;
  localparam logic [15:0] W16 = 16'(WIDTH);
  localparam logic [15:0] H16 = 16'(HEIGHT);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state, state_nx;
  logic fval_q, act_q;
  logic [15:0] col, row, row_le;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt, occ;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic act, frame_start, line_end, frame_end, done, wr_req, full, pop, push, load, last;
  logic [ADDR_W-1:0] addr;
  always_comb begin
    act = b_fval && b_lval;
    frame_start = state == IDLE && b_fval && !fval_q;
    line_end = state == ACTIVE && act_q && !act;
    frame_end = state == ACTIVE && fval_q && !b_fval;
    row_le = row + 16'(line_end && col != '0);
    done = state == DRAIN && cnt == '0 && !out_valid;
    wr_req = state == ACTIVE && act && col < W16 && row < H16;
    // Occupancy includes the output register, so FIFO_DEPTH is the true capacity.
    occ = cnt + (PW+1)'(out_valid);
    full = occ == (PW+1)'(FIFO_DEPTH);
    pop = out_valid && out_ready;
    push = wr_req && (!full || pop);
    load = cnt != '0 && (!out_valid || out_ready);
    addr = ADDR_W'(row * WIDTH + col);
    last = row == H16 - 16'd1 && col == W16 - 16'd1;
    state_nx = frame_start ? ACTIVE : frame_end ? DRAIN : done ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {addr, in_data, last};
  // fval_q resets high so a frame already running at reset release is not mistaken for a new one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fval_q <= 1'b1;
      act_q <= 1'b0;
      col <= '0;
      row <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
      err_line_len <= 1'b0;
      err_line_cnt <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      fval_q <= b_fval;
      act_q <= act;
      if (frame_start) begin
        col <= '0;
        row <= '0;
      end else if (state == ACTIVE) begin
        col <= act ? (col == 16'hFFFF ? col : col + 16'd1) : line_end ? '0 : col;
        row <= row_le;
      end
      err_line_len <= !frame_start && (err_line_len || (line_end && col != '0 && col != W16));
      err_line_cnt <= !frame_start && (err_line_cnt || (frame_end && row_le != H16));
      overflow <= !frame_start && (overflow || (wr_req && !push));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(load);
      out_valid <= load || (out_valid && !out_ready);
      if (load) {out_addr, out_data, out_last} <= mem[rd_ptr];
      frame_done <= done;
      frame_cnt <= frame_cnt + 16'(done);
    end
`ifdef CAPTURE_CRC_EN
  logic [15:0] crc;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DATA_WIDTH-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      crc <= 16'hFFFF;
      frame_crc <= '0;
    end else begin
      crc <= frame_start ? 16'hFFFF : push ? crc_step(crc, in_data) : crc;
      frame_crc <= done ? crc : frame_crc;
    end
`else
  assign frame_crc = '0;
`endif
endmodule

// File: doc/frame_capture_sink.md
# frame_capture_sink

Receive-side endpoint for the frame/line-valid pixel stream produced by the edge-detection pipeline (`b_fval_sync`/`b_lval_sync`/`out_data`). It checks frame geometry, tags each pixel with a linear frame address, and buffers pixels in a FIFO. A valid/ready handshake then drains them to a downstream memory writer. It is the consumer counterpart of the pixel-stream source, used in hardware and as the bench's result-capture stage.

## Interface
- `DATA_WIDTH`, default 16: pixel width.
- `WIDTH`, default 640: expected pixels per line.
- `HEIGHT`, default 512: expected lines per frame.
- `FIFO_DEPTH`, default 1024: FIFO entries; must be a power of two.
- `ADDR_W`, default `$clog2(WIDTH*HEIGHT)`: width of the pixel address.
- `clk`, input, 1: single clock. Every output is registered on `posedge clk`.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `b_fval`, input, 1: frame valid.
- `b_lval`, input, 1: line valid.
- `in_data`, input, DATA_WIDTH: pixel data.
- `out_valid`, output, 1: FIFO head is valid.
- `out_ready`, input, 1: downstream accepts the head entry.
- `out_data`, output, DATA_WIDTH: head pixel.
- `out_addr`, output, ADDR_W: head pixel address, `row*WIDTH+col`.
- `out_last`, output, 1: head pixel is the last one, `addr == WIDTH*HEIGHT-1`.
- `frame_done`, output, 1: one-cycle pulse when a frame is fully drained.
- `frame_cnt`, output, 16: count of completed frames; wraps at 0xFFFF to 0.
- `err_line_len`, output, 1: sticky flag; a line ended with `col != WIDTH`.
- `err_line_cnt`, output, 1: sticky flag; a frame ended with `row != HEIGHT`.
- `overflow`, output, 1: sticky flag; a pixel was dropped because the FIFO was full.
- `frame_crc`, output, 16: per-frame CRC. See Configuration.

## Operation
- FSM states and transitions:
  - IDLE: wait for a rising edge of `b_fval`, detected against a registered copy. On the edge, clear `col`, `row` and all sticky flags, then go to ACTIVE.
  - ACTIVE: every cycle with `b_fval & b_lval` high is one accepted pixel.
    - If `col < WIDTH` and `row < HEIGHT`, push `{addr, in_data, last}` into the FIFO.
    - Otherwise, discard the pixel. `col` still increments, saturating at `2^16-1`.
  - Line end: `b_lval` falling, or `b_fval` falling while `b_lval` is high.
    - If `col != WIDTH` and `col != 0`, set `err_line_len`.
    - If `col != 0`, increment `row`.
    - Clear `col`.
  - On `b_fval` falling, apply the line-end rule first, then check `row`. If `row != HEIGHT`, set `err_line_cnt`. Go to DRAIN.
  - DRAIN: wait for the FIFO to be empty, then pulse `frame_done`, increment `frame_cnt`, and go to IDLE. A `b_fval` rising edge seen in DRAIN is ignored, and that whole frame is skipped.
- FIFO write rule: a write is accepted when `!full || (out_valid && out_ready)` in the same cycle. Otherwise the pixel is dropped and `overflow` is set.
- Handshake:
  - A pop occurs on a cycle where `out_valid && out_ready`.
  - `out_data`/`out_addr`/`out_last` hold stable while `out_valid` is high and `out_ready` is low.
  - `out_valid` never drops without a pop.
- Sticky flags hold their value until the next frame start, or until reset.
- Reset mid-operation: all state clears asynchronously and FIFO contents are discarded. After release, a frame already in progress (`b_fval` high) is ignored until `b_fval` falls and rises again.
- Reset values: `out_valid`, `out_last`, `frame_done`, `err_*`, `overflow` = 0; `out_data`, `out_addr`, `frame_cnt`, `frame_crc` = 0; FSM = IDLE.

## Timing
- Pixel accepted at edge N with the FIFO empty: `out_valid` is high after edge N+1, carrying that pixel. Latency is 1 cycle.
- Throughput: one pixel per clock in and one per clock out, sustained.
- `err_line_len` is visible 1 cycle after the line-end edge.
- `err_line_cnt` is visible 1 cycle after the `b_fval` falling edge.
- `frame_done` asserts on the cycle after the FIFO becomes empty in DRAIN.
- `frame_cnt` updates on the same edge as `frame_done`.

## Configuration
- `CAPTURE_CRC_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) runs over the `in_data` of every pixel pushed into the FIFO.
  - `frame_crc` latches the result on the `frame_done` edge and holds it until the next `frame_done`.
- `CAPTURE_CRC_EN` undefined: `frame_crc` is tied to 0 and no CRC logic is generated.

## Test plan
All scenarios use `WIDTH=8`, `HEIGHT=4`, `FIFO_DEPTH=16`.
1. Nominal frame, `out_ready`=1:
   - Stimulus: 4 lines of 8 pixels with data = addr, 3 blank cycles between lines.
   - Required: 32 outputs with addr 0..31 in order; `out_last` only at addr 31; one `frame_done` pulse; `frame_cnt`=1; no flags set.
2. Short and long lines:
   - Stimulus: line 1 has 6 pixels, line 2 has 10 pixels.
   - Required: `err_line_len`=1; addresses 8..13 are emitted for line 1; pixels 9 and 10 of line 2 are never emitted.
3. Wrong line count:
   - Stimulus: a frame of 3 lines.
   - Required: `err_line_cnt`=1 one cycle after `b_fval` falls; `frame_done` still pulses after drain.
4. Backpressure:
   - Stimulus: `out_ready`=0 for a full 32-pixel frame, then `out_ready`=1.
   - Required: first 16 pixels are emitted; `overflow`=1; outputs hold stable while stalled.
5. Reset mid-frame:
   - Stimulus: assert `rst_n`=0 at pixel 12 of 32.
   - Required: outputs are 0 immediately; the partial frame is not emitted; the next full frame is captured cleanly with addr starting at 0.
6. CRC, with `CAPTURE_CRC_EN` defined:
   - Stimulus: the frame from scenario 1.
   - Required: `frame_crc` equals the reference-model CRC of the 32 words.
